// File: rtl/pc_counter_pkg.sv
// Shared Hack definitions and control-bundle type for the program counter.
package pc_counter_pkg;

    localparam int              HACK_WIDTH        = 16;
    localparam logic [15:0]     HACK_RESET_VECTOR = 16'h0000;

    // Control inputs from the CPU control unit, listed in priority order.
    typedef struct packed {
        logic clr;
        logic load;
        logic inc;
    } pc_ctrl_t;

endpackage

// File: rtl/pc_counter_gates.sv
// Gate primitives used to build the counter datapath, plus the per-bit flop.

module not1 (
    input  logic a,
    output logic y
);
    assign y = ~a;
endmodule

module and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module or2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

module xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// 2:1 mux, y = sel ? b : a, built from the basic gates.
module mux (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    logic sel_n;
    logic pick_a;
    logic pick_b;

    not1 u_not (.a(sel),   .y(sel_n));
    and2 u_and_a (.a(a),   .b(sel_n), .y(pick_a));
    and2 u_and_b (.a(b),   .b(sel),   .y(pick_b));
    or2  u_or  (.a(pick_a), .b(pick_b), .y(y));
endmodule

// One storage bit; async active-low reset forces q to RESET_BIT.
module pc_counter_dff #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    // Bit register with asynchronous reset to the reset-vector bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_BIT;
        end else begin
            q <= d;
        end
    end
endmodule

// File: rtl/pc_counter_inc_n.sv
// WIDTH-bit incrementer: ripple of half adders with carry-in fixed at 1.
// The carry out of the top bit is dropped, so all-ones wraps to zero.
module inc_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum
);
    logic [WIDTH-1:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xor2 u_sum (.a(a[i]), .b(c[i]), .y(sum[i]));
        // Top-bit carry would be discarded, so it is not built at all.
        if (i < WIDTH - 1) begin : g_carry
            and2 u_carry (.a(a[i]), .b(c[i]), .y(c[i+1]));
        end
    end
endmodule

// File: rtl/pc_counter.sv
// Hack program counter: registered PC with clr > load > inc > hold priority.
// Next value comes from a per-bit mux cascade; no combinational path to out.
module pc_counter
    import pc_counter_pkg::*;
#(
    parameter int               WIDTH        = HACK_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(HACK_RESET_VECTOR)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] out
);
    pc_ctrl_t         ctrl;
    logic [WIDTH-1:0] pc_plus1;
    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;
    logic [WIDTH-1:0] stage3;

    assign ctrl = '{clr: clr, load: load, inc: inc};

    inc_n #(.WIDTH(WIDTH)) u_inc (
        .a   (out),
        .sum (pc_plus1)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // Lowest priority first: inc, then load overrides, then clr overrides.
        mux u_inc_mux (
            .a   (out[i]),
            .b   (pc_plus1[i]),
            .sel (ctrl.inc),
            .y   (stage1[i])
        );
        mux u_load_mux (
            .a   (stage1[i]),
            .b   (in[i]),
            .sel (ctrl.load),
            .y   (stage2[i])
        );
        mux u_clr_mux (
            .a   (stage2[i]),
            .b   (RESET_VECTOR[i]),
            .sel (ctrl.clr),
            .y   (stage3[i])
        );
        pc_counter_dff #(.RESET_BIT(RESET_VECTOR[i])) u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (stage3[i]),
            .q     (out[i])
        );
    end
endmodule

// File: tb/tb_pc_counter.sv
// Bench for pc_counter: two instances (reset vector 0 and 16'h0100) driven
// by the same stimulus, checked against a priority-rule model every cycle
// plus directed literal expectations.
module tb_pc_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic        clr;
    logic [15:0] out;
    logic [15:0] out_rv;

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    logic [15:0] m0;
    logic [15:0] m1;

    localparam logic [15:0] RV0 = 16'h0000;
    localparam logic [15:0] RV1 = 16'h0100;

    pc_counter dut (
        .clk(clk), .rst_n(rst_n), .in(in), .load(load),
        .inc(inc), .clr(clr), .out(out)
    );

    pc_counter #(.WIDTH(16), .RESET_VECTOR(RV1)) dut_rv (
        .clk(clk), .rst_n(rst_n), .in(in), .load(load),
        .inc(inc), .clr(clr), .out(out_rv)
    );

    // clock
    always #5 clk = ~clk;

    // reference model: what the PC must hold after each event
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 = RV0;
            m1 = RV1;
        end else if (clr) begin
            m0 = RV0;
            m1 = RV1;
        end else if (load) begin
            m0 = in;
            m1 = in;
        end else if (inc) begin
            m0 = m0 + 16'd1;
            m1 = m1 + 16'd1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(posedge clk) begin
        #1;
        if (checking) begin
            chk("model", out, m0);
            chk("model_rv", out_rv, m1);
        end
    end

    task automatic drive(input logic c, input logic l, input logic i, input logic [15:0] d);
        @(negedge clk);
        clr  = c;
        load = l;
        inc  = i;
        in   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        in = '0; load = 1'b0; inc = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset", out, 16'h0000);
        chk("reset_rv", out_rv, 16'h0100);
        checking = 1'b1;

        // release reset and load 1234
        @(negedge clk);
        rst_n = 1'b1; load = 1'b1; in = 16'h1234;
        tick();
        chk("load1234", out, 16'h1234);
        chk("load1234_rv", out_rv, 16'h1234);

        // reset mid-cycle acts immediately
        @(negedge clk);
        load = 1'b0; inc = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", out, 16'h0000);
        chk("async_rst_rv", out_rv, 16'h0100);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("first_inc", out, 16'h0001);
        chk("first_inc_rv", out_rv, 16'h0101);

        // count from zero
        drive(1, 0, 0, 16'h0000);
        tick();
        chk("clr", out, 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 1, 16'h0000);
            tick();
            chk("count", out, 16'(k));
        end
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 16'hFFFF);
            tick();
            chk("hold", out, 16'h0005);
        end

        // load beats inc
        drive(0, 1, 1, 16'h00A0);
        tick();
        chk("load_prio", out, 16'h00A0);
        drive(0, 0, 1, 16'h0000);
        tick();
        chk("inc_after_load", out, 16'h00A1);

        // wrap
        drive(0, 1, 0, 16'hFFFF);
        tick();
        chk("load_ffff", out, 16'hFFFF);
        drive(0, 0, 1, 16'h0000);
        tick();
        chk("wrap", out, 16'h0000);
        chk("wrap_rv", out_rv, 16'h0000);

        // clr beats load and inc
        drive(0, 1, 0, 16'h0042);
        tick();
        drive(1, 1, 1, 16'h7777);
        tick();
        chk("clr_prio", out, 16'h0000);
        chk("clr_prio_rv", out_rv, 16'h0100);

        // reset falling on the same edge that carries a load
        drive(0, 1, 0, 16'hBEEF);
        @(posedge clk);
        rst_n = 1'b0;
        #2;
        chk("rst_vs_edge", out, 16'h0000);
        chk("rst_vs_edge_rv", out_rv, 16'h0100);

        // unknown inputs under reset must not reach out
        @(negedge clk);
        in = 'x; load = 1'bx; inc = 1'bx; clr = 1'bx;
        tick();
        tick();
        chk("x_in_rst", out, 16'h0000);
        chk("x_in_rst_rv", out_rv, 16'h0100);
        @(negedge clk);
        in = '0; load = 1'b0; inc = 1'b0; clr = 1'b0;
        rst_n = 1'b1;

        // randomized traffic with occasional mid-cycle reset pulses
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            clr  = ($urandom_range(0, 15) == 0);
            load = ($urandom_range(0, 3) == 0);
            inc  = ($urandom_range(0, 3) != 0);
            in   = 16'($urandom_range(0, 65535));
            if (n % 50 == 17) begin
                in = 16'hFFFE;
                load = 1'b1;
                clr = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rand_rst", out, m0);
                chk("rand_rst_rv", out_rv, m1);
                #1 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        checking = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
